// File: rtl/fir_core_pkg.sv
// rtl/fir_core_pkg.sv - shared constants, register map and FSM encodings for fir_core
package fir_core_pkg;

  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 32;
  localparam int TAP_NUM = 11;

  localparam logic [ADDR_W-1:0] REG_AP_CTRL  = 12'h000;
  localparam logic [ADDR_W-1:0] REG_DATA_LEN = 12'h010;
  localparam logic [ADDR_W-1:0] REG_TAP_BASE = 12'h020;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  typedef logic [3:0] tap_idx_t;
  typedef logic [2:0] fsm_state_t;

  localparam fsm_state_t S_IDLE    = 3'd0;
  localparam fsm_state_t S_CLEAR   = 3'd1;
  localparam fsm_state_t S_WAIT_IN = 3'd2;
  localparam fsm_state_t S_MAC     = 3'd3;
  localparam fsm_state_t S_OUT     = 3'd4;
  localparam fsm_state_t S_DONE    = 3'd5;

  function automatic logic is_tap_addr(input logic [ADDR_W-1:0] addr);
    return (addr >= REG_TAP_BASE) && (addr < REG_TAP_BASE + ADDR_W'(4 * TAP_NUM));
  endfunction

  function automatic logic [ADDR_W-1:0] tap_ram_addr(input logic [ADDR_W-1:0] addr);
    return (addr - REG_TAP_BASE) & ~ADDR_W'(3);
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input tap_idx_t idx);
    return ADDR_W'({idx, 2'b00});
  endfunction

  // Circular delay-line pointer arithmetic over words 0..last
  function automatic tap_idx_t wrap_inc(input tap_idx_t idx, input tap_idx_t last);
    return (idx == last) ? '0 : idx + tap_idx_t'(1);
  endfunction

  function automatic tap_idx_t wrap_dec(input tap_idx_t idx, input tap_idx_t last);
    return (idx == '0) ? last : idx - tap_idx_t'(1);
  endfunction

endpackage

// File: rtl/fir_core_if.sv
// rtl/fir_core_if.sv - AXI-Lite config plus ss/sm stream bundle for fir_core
interface fir_core_if;
  import fir_core_pkg::*;

  logic                     awvalid;
  logic                     awready;
  logic [ADDR_W-1:0]        awaddr;
  logic                     wvalid;
  logic                     wready;
  logic [DATA_W-1:0]        wdata;
  logic                     arvalid;
  logic                     arready;
  logic [ADDR_W-1:0]        araddr;
  logic                     rvalid;
  logic                     rready;
  logic [DATA_W-1:0]        rdata;

  logic                     ss_tvalid;
  logic                     ss_tready;
  logic signed [DATA_W-1:0] ss_tdata;
  logic                     ss_tlast;

  logic                     sm_tvalid;
  logic                     sm_tready;
  logic signed [DATA_W-1:0] sm_tdata;
  logic                     sm_tlast;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output awready, wready, arready, rvalid, rdata,
           ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  awready, wready, arready, rvalid, rdata,
           ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

endinterface

// File: rtl/fir_axil_regs.sv
// rtl/fir_axil_regs.sv - AXI-Lite handshakes, ap_ctrl/data_length registers, tap RAM port mux
module fir_axil_regs
  import fir_core_pkg::*;
(
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  fir_core_if.slave         bus,
  input  logic              start_ack,
  input  logic              done_set,
  output logic              ap_start,
  output logic [DATA_W-1:0] data_length,
  input  logic              eng_tap_en,
  input  logic [ADDR_W-1:0] eng_tap_a,
  output logic [3:0]        tap_WE,
  output logic              tap_EN,
  output logic [ADDR_W-1:0] tap_A,
  output logic [DATA_W-1:0] tap_Di,
  input  logic [DATA_W-1:0] tap_Do
);

  logic              ap_idle;
  logic              ap_done;
  logic              wr_ack;
  logic              ar_ack;
  logic              rd_tap_pend;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              wr_ack_nxt;
  logic              ar_ack_nxt;
  logic              wr_fire;
  logic              rd_fire;
  logic              wr_tap;
  logic              rd_tap;
  logic [DATA_W-1:0] rd_value;

  assign bus.awready = wr_ack;
  assign bus.wready  = wr_ack;
  assign bus.arready = ar_ack;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;

  // A read is never accepted in the cycle a write fires, so the tap RAM port has one owner
  assign wr_ack_nxt = bus.awvalid && bus.wvalid && !wr_ack;
  assign ar_ack_nxt = bus.arvalid && !ar_ack && !rd_tap_pend && !rvalid_q && !wr_ack_nxt;

  assign wr_fire = wr_ack && bus.awvalid && bus.wvalid;
  assign rd_fire = ar_ack && bus.arvalid;
  assign wr_tap  = wr_fire && ap_idle && is_tap_addr(bus.awaddr);
  assign rd_tap  = rd_fire && ap_idle && is_tap_addr(bus.araddr);

  always_comb begin
    rd_value = '0;
    if (bus.araddr == REG_AP_CTRL) begin
      rd_value[AP_START_BIT] = ap_start;
      rd_value[AP_DONE_BIT]  = ap_done;
      rd_value[AP_IDLE_BIT]  = ap_idle;
    end else if (bus.araddr == REG_DATA_LEN) begin
      rd_value = data_length;
    end else if (is_tap_addr(bus.araddr)) begin
      rd_value = '1;
    end
  end

  always_comb begin
    tap_EN = eng_tap_en;
    tap_A  = eng_tap_a;
    tap_WE = 4'h0;
    tap_Di = '0;
    if (wr_tap) begin
      tap_EN = 1'b1;
      tap_WE = 4'hF;
      tap_A  = tap_ram_addr(bus.awaddr);
      tap_Di = bus.wdata;
    end else if (rd_tap) begin
      tap_EN = 1'b1;
      tap_A  = tap_ram_addr(bus.araddr);
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ack      <= 1'b0;
      ar_ack      <= 1'b0;
      rd_tap_pend <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      ap_start    <= 1'b0;
      ap_done     <= 1'b0;
      ap_idle     <= 1'b1;
      data_length <= '0;
    end else begin
      wr_ack      <= wr_ack_nxt;
      ar_ack      <= ar_ack_nxt;
      rd_tap_pend <= rd_tap;

      if (wr_fire) begin
        if (bus.awaddr == REG_AP_CTRL) begin
          if (bus.wdata[AP_START_BIT] && ap_idle && !ap_done) ap_start <= 1'b1;
          if (bus.wdata[AP_DONE_BIT]) ap_done <= 1'b0;
        end else if (bus.awaddr == REG_DATA_LEN) begin
          data_length <= bus.wdata;
        end
      end
      // Engine events come last so they win over a same-cycle host write
      if (start_ack) begin
        ap_start <= 1'b0;
        ap_idle  <= 1'b0;
      end
      if (done_set) begin
        ap_done <= 1'b1;
        ap_idle <= 1'b1;
      end

      if (rvalid_q && bus.rready) rvalid_q <= 1'b0;
      if (rd_fire && !rd_tap) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_value;
      end
      if (rd_tap_pend) begin
        rvalid_q <= 1'b1;
        rdata_q  <= tap_Do;
      end
    end
  end

endmodule

// File: rtl/fir_core.sv
// rtl/fir_core.sv - 11-tap FIR engine: delay-line clear, circular sample write, serial MAC, stream output
module fir_core
  import fir_core_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  fir_core_if.slave              bus,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic [3:0]             data_WE,
  output logic                   data_EN,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do
);

  localparam tap_idx_t LAST_TAP = tap_idx_t'(Tape_Num - 1);

  fsm_state_t        state;
  tap_idx_t          clr_cnt;
  tap_idx_t          head;
  tap_idx_t          rd_ptr;
  tap_idx_t          k_cnt;
  logic              p_vld;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] out_cnt;
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] data_length;
  logic              ap_start;
  logic              start_ack;
  logic              done_set;
  logic              out_fire;
  logic              last_out;
  logic              eng_tap_en;
  logic [ADDR_W-1:0] eng_tap_a;
  logic              unused_ss_tlast;

  fir_axil_regs u_regs (
    .axis_clk    (axis_clk),
    .axis_rst_n  (axis_rst_n),
    .bus         (bus),
    .start_ack   (start_ack),
    .done_set    (done_set),
    .ap_start    (ap_start),
    .data_length (data_length),
    .eng_tap_en  (eng_tap_en),
    .eng_tap_a   (eng_tap_a),
    .tap_WE      (tap_WE),
    .tap_EN      (tap_EN),
    .tap_A       (tap_A),
    .tap_Di      (tap_Di),
    .tap_Do      (tap_Do)
  );

  // Input framing comes from data_length alone
  assign unused_ss_tlast = bus.ss_tlast;

  assign start_ack     = (state == S_IDLE) && ap_start;
  assign done_set      = (state == S_DONE);
  assign bus.ss_tready = (state == S_WAIT_IN);
  // The final product lands one cycle into OUT, so valid waits for the pipeline to drain
  assign bus.sm_tvalid = (state == S_OUT) && !p_vld;
  assign bus.sm_tdata  = acc;
  assign last_out      = (out_cnt == data_length - 32'd1);
  assign bus.sm_tlast  = bus.sm_tvalid && last_out;
  assign out_fire      = bus.sm_tvalid && bus.sm_tready;
  assign prod          = tap_Do * data_Do;

  assign eng_tap_en = (state == S_MAC);
  assign eng_tap_a  = word_addr(k_cnt);

  always_comb begin
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A  = '0;
    data_Di = '0;
    case (state)
      S_CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A  = word_addr(clr_cnt);
      end
      S_WAIT_IN: begin
        if (bus.ss_tvalid) begin
          data_EN = 1'b1;
          data_WE = 4'hF;
          data_A  = word_addr(head);
          data_Di = bus.ss_tdata;
        end
      end
      S_MAC: begin
        data_EN = 1'b1;
        data_A  = word_addr(rd_ptr);
      end
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      head    <= '0;
      rd_ptr  <= '0;
      k_cnt   <= '0;
      p_vld   <= 1'b0;
      acc     <= '0;
      out_cnt <= '0;
    end else begin
      p_vld <= (state == S_MAC);
      if (p_vld) acc <= acc + prod;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            head    <= '0;
            out_cnt <= '0;
          end
        end
        S_CLEAR: begin
          clr_cnt <= clr_cnt + tap_idx_t'(1);
          if (clr_cnt == LAST_TAP) state <= S_WAIT_IN;
        end
        S_WAIT_IN: begin
          if (bus.ss_tvalid) begin
            rd_ptr <= head;
            head   <= wrap_inc(head, LAST_TAP);
            k_cnt  <= '0;
            acc    <= '0;
            state  <= S_MAC;
          end
        end
        S_MAC: begin
          // Tap k pairs with the sample k positions behind the newest one
          k_cnt  <= k_cnt + tap_idx_t'(1);
          rd_ptr <= wrap_dec(rd_ptr, LAST_TAP);
          if (k_cnt == LAST_TAP) state <= S_OUT;
        end
        S_OUT: begin
          if (out_fire) begin
            out_cnt <= out_cnt + 32'd1;
            state   <= (out_cnt + 32'd1 >= data_length) ? S_DONE : S_WAIT_IN;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_core.sv
// tb/tb_fir_core.sv - directed bench for fir_core with bram11 models and a golden FIR model
module tb_fir_core;
  import fir_core_pkg::*;

  logic axis_clk = 1'b0;
  logic axis_rst_n;
  always #5 axis_clk = ~axis_clk;

  fir_core_if bus ();

  logic [3:0]  tap_WE, data_WE;
  logic        tap_EN, data_EN;
  logic [11:0] tap_A, data_A;
  logic [31:0] tap_Di, data_Di, tap_Do, data_Do;
  logic [31:0] tap_mem  [0:10];
  logic [31:0] data_mem [0:10];

  fir_core dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .bus        (bus),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_A      (tap_A),
    .tap_Di     (tap_Di),
    .tap_Do     (tap_Do),
    .data_WE    (data_WE),
    .data_EN    (data_EN),
    .data_A     (data_A),
    .data_Di    (data_Di),
    .data_Do    (data_Do)
  );

  always @(posedge axis_clk) begin
    if (tap_EN && tap_A[11:2] < 10'd11) begin
      if (tap_WE == 4'hF) tap_mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= tap_mem[tap_A[5:2]];
    end
  end

  always @(posedge axis_clk) begin
    if (data_EN && data_A[11:2] < 10'd11) begin
      if (data_WE == 4'hF) data_mem[data_A[5:2]] <= data_Di;
      data_Do <= data_mem[data_A[5:2]];
    end
  end

  int errors = 0;
  int checks = 0;
  int taps_m [11];
  int xs [$];
  int ys [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
    int t = 0;
    bus.awaddr  = a;
    bus.wdata   = d;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    do begin tick(); t++; end while (!bus.awready && t < 50);
    chk("axil_wr_handshake", {31'b0, bus.awready & bus.wready}, 32'd1);
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d);
    int t = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    do begin tick(); t++; end while (!bus.arready && t < 50);
    chk("axil_ar_handshake", {31'b0, bus.arready}, 32'd1);
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    t = 0;
    while (!bus.rvalid && t < 50) begin tick(); t++; end
    chk("axil_rvalid", {31'b0, bus.rvalid}, 32'd1);
    d = bus.rdata;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic write_taps();
    for (int k = 0; k < 11; k++) axil_write(12'h020 + 12'(4 * k), taps_m[k]);
  endtask

  task automatic build_expected();
    ys.delete();
    for (int n = 0; n < xs.size(); n++) begin
      int a = 0;
      for (int k = 0; k < 11; k++) if (n - k >= 0) a += taps_m[k] * xs[n - k];
      ys.push_back(a);
    end
  endtask

  // mode 0: feed before ap_start, then start; mode 1: host accesses while busy; mode 2: back-pressure
  task automatic run_stream(input int mode);
    int n = xs.size();
    fork
      begin
        int fed = 0;
        int t;
        for (int i = 0; i < n; i++) begin
          if (mode == 2) begin
            bus.ss_tvalid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
          end
          bus.ss_tvalid = 1'b1;
          bus.ss_tdata  = xs[i];
          bus.ss_tlast  = (i == n - 1);
          t = 0;
          while (!bus.ss_tready && t < 300) begin tick(); t++; end
          if (!bus.ss_tready) break;
          tick();
          fed++;
        end
        bus.ss_tvalid = 1'b0;
        chk("samples_fed", fed, n);
      end
      begin
        int got = 0;
        int t = 0;
        while (got < n && t < n * 60 + 500) begin
          bus.sm_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
          if (bus.sm_tvalid && bus.sm_tready) begin
            chk($sformatf("y[%0d]", got), bus.sm_tdata, ys[got]);
            chk($sformatf("tlast[%0d]", got), {31'b0, bus.sm_tlast}, {31'b0, got == n - 1});
            got++;
          end
          tick();
          t++;
        end
        bus.sm_tready = 1'b0;
        chk("outputs_seen", got, n);
      end
      begin
        if (mode == 0) begin
          logic seen = 1'b0;
          repeat (20) begin tick(); seen |= bus.ss_tready; end
          chk("pre_start_tready", {31'b0, seen}, 32'd0);
          axil_write(REG_AP_CTRL, 32'h1);
        end else if (mode == 1) begin
          repeat (60) tick();
          rd_chk("busy_ctrl", REG_AP_CTRL, 32'h0);
          rd_chk("busy_tap_read", 12'h020, 32'hFFFF_FFFF);
          axil_write(12'h034, 32'd12345);
        end
      end
    join
    repeat (3) tick();
  endtask

  initial begin
    logic seen;
    int pulses;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    bus.awaddr = '0; bus.wdata = 32'h1; bus.araddr = '0; bus.rready = 1'b0;
    bus.ss_tvalid = 1'b0; bus.ss_tdata = '0; bus.ss_tlast = 1'b0; bus.sm_tready = 1'b0;
    axis_rst_n = 1'b0;
    repeat (4) tick();
    chk("rst_handshakes", {25'b0, bus.awready, bus.wready, bus.arready, bus.rvalid,
        bus.ss_tready, bus.sm_tvalid, bus.sm_tlast}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_sm_tdata", bus.sm_tdata, 32'd0);
    chk("rst_ram_ctl", {22'b0, tap_EN, data_EN, tap_WE, data_WE}, 32'd0);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    axis_rst_n = 1'b1;
    tick();
    rd_chk("ctrl_reset", REG_AP_CTRL, 32'h4);
    rd_chk("dlen_reset", REG_DATA_LEN, 32'h0);

    taps_m = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    write_taps();
    axil_write(REG_DATA_LEN, 32'd600);
    for (int k = 0; k < 11; k++)
      rd_chk($sformatf("tap_rb[%0d]", k), 12'h020 + 12'(4 * k), taps_m[k]);
    rd_chk("dlen_rb", REG_DATA_LEN, 32'd600);
    axil_write(12'h04C, 32'd77);
    rd_chk("unmapped_past_taps", 12'h04C, 32'h0);
    rd_chk("unmapped_04", 12'h004, 32'h0);
    rd_chk("tap10_intact", 12'h048, 32'h0);

    axil_write(REG_DATA_LEN, 32'd12);
    xs.delete();
    xs.push_back(1);
    repeat (11) xs.push_back(0);
    build_expected();
    run_stream(0);
    rd_chk("ctrl_done_impulse", REG_AP_CTRL, 32'h6);

    axil_write(REG_AP_CTRL, 32'h1);
    seen = 1'b0;
    repeat (20) begin tick(); seen |= bus.ss_tready; end
    chk("no_restart_while_done", {31'b0, seen}, 32'd0);
    rd_chk("ctrl_still_done", REG_AP_CTRL, 32'h6);
    axil_write(REG_AP_CTRL, 32'h2);
    rd_chk("ctrl_done_cleared", REG_AP_CTRL, 32'h4);

    axil_write(REG_DATA_LEN, 32'd600);
    xs.delete();
    for (int i = 0; i < 600; i++)
      xs.push_back(((i % 40) < 20) ? (i % 40) * 50 - 500 : (40 - (i % 40)) * 50 - 500);
    build_expected();
    axil_write(REG_AP_CTRL, 32'h1);
    run_stream(1);
    rd_chk("ctrl_done_tri", REG_AP_CTRL, 32'h6);

    bus.awaddr = REG_AP_CTRL; bus.wdata = 32'h1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    seen = 1'b0;
    pulses = 0;
    repeat (40) begin tick(); seen |= bus.ss_tready; pulses += int'(bus.awready); end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    chk("stale_writes_taken", {31'b0, pulses >= 10}, 32'd1);
    chk("stale_start_no_run", {31'b0, seen}, 32'd0);
    rd_chk("ctrl_done_persists", REG_AP_CTRL, 32'h6);
    rd_chk("busy_tap_write_ignored", 12'h034, 32'd63);

    axil_write(REG_AP_CTRL, 32'h2);
    for (int k = 0; k < 11; k++) taps_m[k] = int'($urandom());
    write_taps();
    axil_write(REG_DATA_LEN, 32'd40);
    xs.delete();
    for (int i = 0; i < 40; i++) xs.push_back(int'($urandom()));
    build_expected();
    axil_write(REG_AP_CTRL, 32'h1);
    run_stream(2);
    rd_chk("ctrl_done_bp", REG_AP_CTRL, 32'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
